fifo_32b: RTL and testbench

Word buffer placed directly downstream of the 8b→32b converter (m8b_32b). It captures each 32-bit word the converter presents with its valid strobe, holds up to DEPTH words in arrival order, and releases them one at a time on a pop request. It absorbs rate mismatch between the converter and the consuming logic and flags overflow and underflow events.

---
 rtl/fifo_32b.sv | 104 ++++++++++
 tb/tb_fifo_32b.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fifo_32b.sv
// Word FIFO behind the 8b->32b converter: DEPTH-entry circular buffer with a registered
// head output, occupancy flags and a sticky overflow/underflow error.
module fifo_32b #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int ADDR_W     = 3,
   parameter int AF_THRESH  = 6,
   parameter int AE_THRESH  = 2
) (
   input  logic                  clk_f,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_W:0]       count,
   output logic                  error
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
   localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]       count_q, count_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  valid_out_q, valid_out_d;
   logic                  error_q, error_d;

   logic push_acc, pop_acc, overflow, underflow;

   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);

   // A pop frees a slot in the same cycle, so a full FIFO can still take a push alongside it.
   assign push_acc  = valid_in && (!full || pop);
   assign pop_acc   = pop && !empty;
   assign overflow  = valid_in && full && !pop;
   assign underflow = pop && empty;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      data_out_d  = data_out_q;
      valid_out_d = pop_acc;
      error_d     = error_q || overflow || underflow;

      if (push_acc) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_acc) begin
         rd_ptr_d   = rd_ptr_q + 1'b1;
         data_out_d = mem_q[rd_ptr_q];
      end

      case ({push_acc, pop_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_f or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         data_out_q  <= '0;
         valid_out_q <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
         error_q     <= error_d;
      end
   end

   // Storage is deliberately not reset; count=0 makes stale entries unreachable.
   always_ff @(posedge clk_f) begin
      if (push_acc) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;
   assign count     = count_q;
   assign error     = error_q;

endmodule

// File: tb/tb_fifo_32b.sv
// Directed bench for fifo_32b: a queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_fifo_32b;

   logic        clk_f = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] data_in = '0;
   logic        valid_in = 1'b0;
   logic        pop = 1'b0;
   logic [31:0] data_out;
   logic        valid_out, full, empty, almost_full, almost_empty, error;
   logic [3:0]  count;

   fifo_32b dut (
      .clk_f(clk_f), .reset(reset), .data_in(data_in), .valid_in(valid_in), .pop(pop),
      .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count), .error(error)
   );

   always #5 clk_f = ~clk_f;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: contents as a queue, outputs derived from the occupancy rules.
   logic [31:0] mq[$];
   logic [31:0] m_data = '0;
   logic        m_valid = 1'b0;
   logic        m_err = 1'b0;

   always @(posedge clk_f or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_data  = '0;
         m_valid = 1'b0;
         m_err   = 1'b0;
      end else begin
         bit do_push, do_pop;
         do_push = valid_in && (mq.size() < 8 || pop);
         do_pop  = pop && mq.size() > 0;
         if (valid_in && mq.size() == 8 && !pop) m_err = 1'b1;
         if (pop && mq.size() == 0) m_err = 1'b1;
         m_valid = do_pop;
         if (do_pop) m_data = mq.pop_front();
         if (do_push) mq.push_back(data_in);
      end
   end

   always @(negedge clk_f) begin
      if (chk_en) begin
         int sz;
         sz = mq.size();
         check("count",        32'(count),        32'(sz));
         check("full",         32'(full),         32'(sz == 8));
         check("empty",        32'(empty),        32'(sz == 0));
         check("almost_full",  32'(almost_full),  32'(sz >= 6));
         check("almost_empty", 32'(almost_empty), 32'(sz <= 2));
         check("valid_out",    32'(valid_out),    32'(m_valid));
         check("data_out",     data_out,          m_data);
         check("error",        32'(error),        32'(m_err));
      end
   end

   // Drive one cycle of inputs at a falling edge and return at the next falling edge.
   task automatic cyc(input logic v, input logic [31:0] d, input logic p);
      valid_in = v;
      data_in  = d;
      pop      = p;
      @(negedge clk_f);
      valid_in = 1'b0;
      pop      = 1'b0;
   endtask

   task automatic reset_pulse();
      #2 reset = 1'b1;
      #1;
      check("rst_data_out", data_out, 32'h0);
      check("rst_count",    32'(count), 32'd0);
      check("rst_empty",    32'(empty), 32'd1);
      check("rst_error",    32'(error), 32'd0);
      #1 reset = 1'b0;
   endtask

   logic [31:0] fill_words [8] = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD,
                                   32'hEEEEEEEE, 32'hFFFFFFFF, 32'h00000000, 32'h03020100};

   initial begin
      reset_pulse();
      chk_en = 1;
      @(negedge clk_f);

      // Fill and drain
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, fill_words[i], 1'b0);
         if (i == 4) check("af_at_5", 32'(almost_full), 32'd0);
         if (i == 5) check("af_at_6", 32'(almost_full), 32'd1);
      end
      check("fill_count", 32'(count), 32'd8);
      check("fill_full",  32'(full),  32'd1);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, '0, 1'b1);
         check("drain_word", data_out, fill_words[i]);
         check("drain_valid", 32'(valid_out), 32'd1);
      end
      cyc(1'b0, '0, 1'b0);
      check("drain_valid_low", 32'(valid_out), 32'd0);
      check("drain_empty", 32'(empty), 32'd1);
      check("drain_error", 32'(error), 32'd0);

      // Refill, overflow, then push+pop while full
      for (int i = 0; i < 8; i++) cyc(1'b1, fill_words[i], 1'b0);
      cyc(1'b1, 32'h07060504, 1'b0);
      check("ovf_count", 32'(count), 32'd8);
      check("ovf_error", 32'(error), 32'd1);
      cyc(1'b1, 32'h11111111, 1'b1);
      check("full_pp_data",  data_out, 32'hAAAAAAAA);
      check("full_pp_count", 32'(count), 32'd8);
      for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
      check("full_pp_last", data_out, 32'h11111111);
      check("full_pp_empty", 32'(empty), 32'd1);

      // Underflow from a clean state
      reset_pulse();
      @(negedge clk_f);
      cyc(1'b1, 32'h55555555, 1'b0);
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b1);
      check("unf_valid", 32'(valid_out), 32'd0);
      check("unf_data",  data_out, 32'h55555555);
      check("unf_error", 32'(error), 32'd1);
      cyc(1'b1, 32'h22222222, 1'b1);
      check("unf_push_count", 32'(count), 32'd1);
      cyc(1'b0, '0, 1'b1);
      check("unf_push_data", data_out, 32'h22222222);

      // Wrap the pointers, then reset with words still stored
      for (int i = 0; i < 5; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1);
      for (int i = 0; i < 6; i++) cyc(1'b1, 32'h200 + 32'(i), 1'b0);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, '0, 1'b1);
         check("wrap_word", data_out, 32'h200 + 32'(i));
      end
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'h300 + 32'(i), 1'b0);
      reset_pulse();
      @(negedge clk_f);
      cyc(1'b1, 32'h0A0B0C0D, 1'b0);
      cyc(1'b0, '0, 1'b1);
      check("post_rst_data", data_out, 32'h0A0B0C0D);
      cyc(1'b0, '0, 1'b0);

      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
